// File: rtl/rs_ser_chk.sv
`default_nettype none
// ============================================================================
// Module   : rs_ser_chk
// Function : Serial Reed-Solomon codeword checker. Computes all syndromes on
//            the fly, strips the check symbols through a delay line and
//            forwards only the data symbols, then reports a per-packet
//            pass/fail status one cycle after the codeword ends.
// Revision : 1.0 - initial release
// ============================================================================
module rs_ser_chk #(
  parameter int BITSPERSYMBOL = 8,
  parameter int CHECK         = 32,
  parameter int IRRPOL        = 285,
  parameter int GENSTART      = 4,
  parameter int ROOTSPACE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITSPERSYMBOL-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  output logic [BITSPERSYMBOL-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     chk_valid,
  output logic                     chk_error,
  output logic                     chk_short
);

  localparam int                       c_fill_w = $clog2(CHECK + 1);
  localparam int                       c_order  = (1 << BITSPERSYMBOL) - 1;
  // Reduction term: primitive polynomial without its x^m term.
  localparam logic [BITSPERSYMBOL-1:0] c_poly   = BITSPERSYMBOL'(IRRPOL);

  // Multiply by x (alpha) with modular reduction.
  function automatic logic [BITSPERSYMBOL-1:0] gf_xtime(input logic [BITSPERSYMBOL-1:0] a);
    logic [BITSPERSYMBOL-1:0] sh;
    sh = {a[BITSPERSYMBOL-2:0], 1'b0};
    return a[BITSPERSYMBOL-1] ? (sh ^ c_poly) : sh;
  endfunction

  // Shift-and-add GF(2^m) multiply; with a constant operand this folds into
  // a fixed XOR network.
  function automatic logic [BITSPERSYMBOL-1:0] gf_mul(input logic [BITSPERSYMBOL-1:0] a,
                                                      input logic [BITSPERSYMBOL-1:0] b);
    logic [BITSPERSYMBOL-1:0] acc;
    logic [BITSPERSYMBOL-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < BITSPERSYMBOL; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // alpha^e, evaluated at elaboration time for the generator roots.
  function automatic logic [BITSPERSYMBOL-1:0] alpha_pow(input int e);
    logic [BITSPERSYMBOL-1:0] p;
    p    = '0;
    p[0] = 1'b1;
    for (int i = 0; i < e; i++) p = gf_xtime(p);
    return p;
  endfunction

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [c_fill_w-1:0]       r_fill;
  logic [BITSPERSYMBOL-1:0]  r_syn      [CHECK];
  logic [BITSPERSYMBOL-1:0]  w_syn_next [CHECK];
  logic [CHECK-1:0]          w_syn_nz;
  logic [BITSPERSYMBOL-1:0]  r_dly_data [CHECK];
  logic [CHECK-1:0]          r_dly_sop;

  logic w_full;
  logic w_accept;
  logic w_take;
  logic w_push;
  logic w_end;
  logic w_short;

  assign w_full   = (r_fill == c_fill_w'(CHECK));
  // Stall input only when the line is full and the output register cannot drain.
  assign in_ready = rst & ~(w_full & out_valid & ~out_ready);
  assign w_accept = in_valid & in_ready;

  // One constant multiplier per syndrome root.
  for (genvar j = 0; j < CHECK; j++) begin : g_syn
    localparam logic [BITSPERSYMBOL-1:0] c_root = alpha_pow((GENSTART + j * ROOTSPACE) % c_order);
    assign w_syn_next[j] = in_startofpacket ? in_data : (gf_mul(r_syn[j], c_root) ^ in_data);
    assign w_syn_nz[j]   = |w_syn_next[j];
  end

  // Packet state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and per-beat qualifiers.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_push       = 1'b0;
    w_end        = 1'b0;
    w_short      = 1'b0;
    if (w_accept) begin
      if (in_startofpacket) begin
        w_state_next = in_endofpacket ? S_IDLE : S_PKT;
        w_take       = 1'b1;
      end else if (r_state == S_PKT) begin
        w_take = 1'b1;
        if (in_endofpacket) w_state_next = S_IDLE;
      end
    end
    // A sop beat restarts the line, so it never pushes buffered data out.
    w_push  = w_take & ~in_startofpacket & w_full;
    w_end   = w_take & in_endofpacket;
    w_short = in_startofpacket | ~w_full;
  end

  // Syndrome accumulators, Horner form per root.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < CHECK; j++) r_syn[j] <= '0;
    end else if (w_take) begin
      for (int j = 0; j < CHECK; j++) r_syn[j] <= w_syn_next[j];
    end
  end

  // Delay line holding {data, sop}; the fill counter qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_dly_data[0] <= in_data;
      r_dly_sop[0]  <= in_startofpacket;
      for (int i = 1; i < CHECK; i++) begin
        r_dly_data[i] <= r_dly_data[i-1];
        r_dly_sop[i]  <= r_dly_sop[i-1];
      end
    end
  end

  // Fill count, output register and status pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fill            <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_data          <= '0;
      chk_valid         <= 1'b0;
      chk_error         <= 1'b0;
      chk_short         <= 1'b0;
    end else begin
      chk_valid <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (w_push) begin
        out_valid         <= 1'b1;
        out_data          <= r_dly_data[CHECK-1];
        out_startofpacket <= r_dly_sop[CHECK-1];
        out_endofpacket   <= in_endofpacket;
      end
      if (w_take) begin
        if (in_endofpacket)        r_fill <= '0;
        else if (in_startofpacket) r_fill <= c_fill_w'(1);
        else if (!w_full)          r_fill <= r_fill + c_fill_w'(1);
      end
      if (w_end) begin
        chk_valid <= 1'b1;
        chk_short <= w_short;
        chk_error <= w_short | (|w_syn_nz);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_ser_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_ser_chk
// Function : Scoreboard bench for rs_ser_chk. Codewords come from a table
//            based systematic encoder; expected status comes from direct
//            polynomial evaluation at each generator root.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_ser_chk;
  localparam int M         = 8;
  localparam int CHECK     = 32;
  localparam int IRRPOL    = 285;
  localparam int GENSTART  = 4;
  localparam int ROOTSPACE = 1;
  localparam int ORD       = (1 << M) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_startofpacket;
  logic         in_endofpacket;
  logic [M-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic         chk_valid;
  logic         chk_error;
  logic         chk_short;

  rs_ser_chk #(
    .BITSPERSYMBOL(M), .CHECK(CHECK), .IRRPOL(IRRPOL),
    .GENSTART(GENSTART), .ROOTSPACE(ROOTSPACE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .chk_valid(chk_valid), .chk_error(chk_error), .chk_short(chk_short)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int exp_t [256];
  int log_t [256];
  int gen   [CHECK+1];

  logic [9:0]   exp_q [$];   // {sop, eop, data}
  logic [1:0]   st_q  [$];   // {error, short}
  logic [M-1:0] pkt_q [$];   // codeword under test

  int fill_m  = 0;
  bit in_pkt  = 0;
  bit gaps    = 0;
  bit bp_mode = 0;
  int cyc     = 0;

  logic [9:0] mon_e;
  logic [1:0] mon_s;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % ORD];
  endfunction

  task automatic init_field();
    int x;
    x = 1;
    for (int i = 0; i < ORD; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & (1 << M)) != 0) x = x ^ IRRPOL;
    end
    for (int d = 0; d <= CHECK; d++) gen[d] = 0;
    gen[0] = 1;
    for (int j = 0; j < CHECK; j++) begin
      int r;
      r = exp_t[(GENSTART + j * ROOTSPACE) % ORD];
      for (int d = j + 1; d >= 0; d--)
        gen[d] = ((d > 0) ? gen[d-1] : 0) ^ gmul(gen[d], r);
    end
  endtask

  // Systematic encode: remainder of d(x)*x^CHECK mod g(x) appended.
  task automatic build_cw(input int k, input bit rnd);
    int rem [CHECK];
    int d, fb;
    pkt_q.delete();
    for (int t = 0; t < CHECK; t++) rem[t] = 0;
    for (int i = 0; i < k; i++) begin
      d = rnd ? int'($urandom_range(0, ORD)) : 0;
      pkt_q.push_back(M'(d));
      fb = d ^ rem[CHECK-1];
      for (int t = CHECK - 1; t > 0; t--) rem[t] = rem[t-1] ^ gmul(fb, gen[t]);
      rem[0] = gmul(fb, gen[0]);
    end
    for (int t = CHECK - 1; t >= 0; t--) pkt_q.push_back(M'(rem[t]));
  endtask

  // Evaluate the received polynomial at every generator root.
  function automatic bit syn_bad();
    int n, e, s;
    n = pkt_q.size();
    for (int j = 0; j < CHECK; j++) begin
      e = (GENSTART + j * ROOTSPACE) % ORD;
      s = 0;
      for (int i = 0; i < n; i++)
        s = s ^ gmul(int'(pkt_q[i]), exp_t[(e * (n - 1 - i)) % ORD]);
      if (s != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_expect_full();
    int n;
    n = pkt_q.size();
    if (n <= CHECK) begin
      st_q.push_back(2'b11);
    end else begin
      for (int i = 0; i < n - CHECK; i++)
        exp_q.push_back({(i == 0), (i == n - CHECK - 1), pkt_q[i]});
      st_q.push_back({syn_bad(), 1'b0});
    end
  endtask

  task automatic send_beat(input logic [M-1:0] d, input logic s, input logic e);
    int t;
    if (gaps) begin
      int g;
      g = int'($urandom_range(0, 2));
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = s;
    in_endofpacket = e;
    t = 0;
    @(negedge clk);
    chk("in_ready", in_ready, !(fill_m == CHECK && out_valid && !out_ready));
    while (!in_ready) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("in_ready", in_ready, !(fill_m == CHECK && out_valid && !out_ready));
      t++;
      if (t > 500) begin
        $display("FAIL in_ready_timeout actual=0 required=1");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (s) begin
      in_pkt = !e;
      fill_m = e ? 0 : 1;
    end else if (in_pkt) begin
      if (e) begin
        in_pkt = 0;
        fill_m = 0;
      end else if (fill_m < CHECK) begin
        fill_m++;
      end
    end
  endtask

  task automatic drive_pkt(input int n, input bit eop_last);
    for (int i = 0; i < n; i++)
      send_beat(pkt_q[i], (i == 0), eop_last && (i == n - 1));
  endtask

  // Downstream ready pattern: one low cycle in three when back-pressuring.
  always @(posedge clk) begin
    #1;
    cyc++;
    out_ready = bp_mode ? ((cyc % 3) != 0) : 1'b1;
  end

  // Scoreboard monitor: compare every output handshake and status pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_beat_unexpected actual=0x%0h required=none",
                   {out_startofpacket, out_endofpacket, out_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_beat", {out_startofpacket, out_endofpacket, out_data}, mon_e);
        end
      end
      if (chk_valid) begin
        if (st_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL status_unexpected actual=%0b required=none", {chk_error, chk_short});
        end else begin
          mon_s = st_q.pop_front();
          chk("status", {chk_error, chk_short}, mon_s);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sop"}, out_startofpacket, 0);
    chk({tag, "_out_eop"}, out_endofpacket, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_chk_valid"}, chk_valid, 0);
    chk({tag, "_chk_error"}, chk_error, 0);
    chk({tag, "_chk_short"}, chk_short, 0);
  endtask

  initial begin
    int w;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    out_ready = 1'b1;
    init_field();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Stray beats outside a packet are dropped.
    send_beat(8'h55, 1'b0, 1'b0);
    send_beat(8'hAA, 1'b0, 1'b1);
    send_beat(8'h01, 1'b0, 1'b0);

    // All-zero full-length codeword.
    build_cw(223, 1'b0);
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);

    // Random codeword, then the same with one bit flipped in symbol 10.
    build_cw(223, 1'b1);
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);
    pkt_q[10] = pkt_q[10] ^ 8'h08;
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);

    // Back-pressure with random input gaps.
    bp_mode = 1'b1;
    gaps = 1'b1;
    for (int p = 0; p < 3; p++) begin
      build_cw(int'($urandom_range(40, 120)), 1'b1);
      if (p == 2) pkt_q[5] = pkt_q[5] ^ 8'h40;
      push_expect_full();
      drive_pkt(pkt_q.size(), 1'b1);
    end
    bp_mode = 1'b0;
    gaps = 1'b0;

    // Boundary lengths: CHECK+1 (one data symbol), CHECK, 20, and 1.
    build_cw(1, 1'b1);
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);
    pkt_q.delete();
    for (int i = 0; i < CHECK; i++) pkt_q.push_back(M'($urandom_range(0, ORD)));
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);
    pkt_q.delete();
    for (int i = 0; i < 20; i++) pkt_q.push_back(M'($urandom_range(0, ORD)));
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);
    pkt_q.delete();
    pkt_q.push_back(8'h3C);
    push_expect_full();
    drive_pkt(1, 1'b1);

    // Reset in the middle of a packet at symbol 50.
    build_cw(100, 1'b1);
    for (int i = 0; i < 50 - CHECK; i++) exp_q.push_back({(i == 0), 1'b0, pkt_q[i]});
    drive_pkt(50, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = pkt_q[50];
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    fill_m = 0;
    in_pkt = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    build_cw(223, 1'b1);
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);

    // Abort at symbol 100 by a new sop, followed by a full codeword.
    build_cw(150, 1'b1);
    for (int i = 0; i < 100 - CHECK; i++) exp_q.push_back({(i == 0), 1'b0, pkt_q[i]});
    drive_pkt(100, 1'b0);
    build_cw(223, 1'b1);
    push_expect_full();
    drive_pkt(pkt_q.size(), 1'b1);

    // Drain.
    w = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("exp_q_left", exp_q.size(), 0);
    chk("st_q_left", st_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
